// File: rtl/cpu64_obi_host_driver_mo.sv
// cpu64_obi_host_driver_mo: OBI host driver with bounded outstanding transactions and flush.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   rd_i, wr_i            upstream read / write request (write wins when WR_EN)
//   be_i, addr_i, wdata_i upstream request attributes
//   stall_i               blocks acceptance of new upstream requests
//   flush_i               discard responses of every in-flight transaction
//   accept_ao             upstream request consumed this cycle
//   req_o, gnt_i          OBI request handshake
//   we_ao, be_ao, addr_ao, wdata_ao  OBI request attributes
//   rvalid_i, rdata_i, err_i         OBI response
//   rvalid_o, rdata_o, err_o, rwe_o  response forwarded upstream, tagged with its type
//   busy_o                any transaction held or outstanding
module cpu64_obi_host_driver_mo #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 39,
    parameter int BE_BITS = DATA_W / 8,
    parameter int MAX_OUT = 2,
    parameter bit WR_EN   = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rd_i,
    input  logic               wr_i,
    input  logic [BE_BITS-1:0] be_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               accept_ao,
    output logic               req_o,
    input  logic               gnt_i,
    output logic               we_ao,
    output logic [BE_BITS-1:0] be_ao,
    output logic [ADDR_W-1:0]  addr_ao,
    output logic [DATA_W-1:0]  wdata_ao,
    input  logic               rvalid_i,
    input  logic [DATA_W-1:0]  rdata_i,
    input  logic               err_i,
    output logic               rvalid_o,
    output logic [DATA_W-1:0]  rdata_o,
    output logic               err_o,
    output logic               rwe_o,
    output logic               busy_o
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic               r_pend_v;
    logic               r_pend_we;
    logic [BE_BITS-1:0] r_pend_be;
    logic [ADDR_W-1:0]  r_pend_addr;
    logic [DATA_W-1:0]  r_pend_wdata;
    logic [CW-1:0]      r_out_cnt;
    logic [CW-1:0]      r_drop_cnt;
    // Type FIFO padded to a power of two so the pointer indexes it cleanly;
    // pointers still wrap at MAX_OUT.
    logic [2**PW-1:0]   r_type;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;

    logic               w_we_dir;
    logic               w_new_req;
    logic               w_cap_ok;
    logic               w_push;
    logic               w_pop;
    logic [CW-1:0]      w_inflight;
    logic [PW-1:0]      w_wr_ptr_nxt;
    logic [PW-1:0]      w_rd_ptr_nxt;

    assign w_we_dir  = wr_i & WR_EN;
    assign w_new_req = rd_i | w_we_dir;
    // A response arriving this cycle does not free its slot until the next one.
    assign w_cap_ok  = ~r_pend_v & (r_out_cnt < CW'(MAX_OUT)) & ~stall_i & ~flush_i & ~rst_i;
    assign accept_ao = w_new_req & w_cap_ok;

    // A held request owns the bus attributes until granted; otherwise the
    // upstream request passes straight through.
    assign req_o    = ~rst_i & (r_pend_v | accept_ao);
    assign we_ao    = WR_EN & (r_pend_v ? r_pend_we : w_we_dir);
    assign be_ao    = r_pend_v ? r_pend_be : be_i;
    assign addr_ao  = r_pend_v ? r_pend_addr : addr_i;
    assign wdata_ao = r_pend_v ? r_pend_wdata : wdata_i;

    assign w_push     = req_o & gnt_i;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_pop      = rvalid_i & (r_out_cnt != '0);
    assign w_inflight = r_out_cnt + CW'(r_pend_v);

    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(MAX_OUT - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(MAX_OUT - 1)) ? '0 : r_rd_ptr + PW'(1);

    assign rvalid_o = rvalid_i & ~flush_i & (r_drop_cnt == '0) & ~rst_i;
    assign rdata_o  = rdata_i;
    assign err_o    = err_i & rvalid_o;
    assign rwe_o    = r_type[r_rd_ptr];
    assign busy_o   = ~rst_i & ((r_out_cnt != '0) | r_pend_v);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_v   <= 1'b0;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (accept_ao & ~gnt_i)
                r_pend_v <= 1'b1;
            else if (r_pend_v & gnt_i)
                r_pend_v <= 1'b0;
            r_out_cnt <= r_out_cnt + CW'(w_push) - CW'(w_pop);
            if (w_push)
                r_wr_ptr <= w_wr_ptr_nxt;
            if (w_pop)
                r_rd_ptr <= w_rd_ptr_nxt;
            // Flush marks everything still in flight as stale, minus the
            // response being swallowed right now.
            if (flush_i)
                r_drop_cnt <= w_inflight - CW'(w_pop);
            else if (rvalid_i & (r_drop_cnt != '0))
                r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept_ao & ~gnt_i) begin
            r_pend_we    <= w_we_dir;
            r_pend_be    <= be_i;
            r_pend_addr  <= addr_i;
            r_pend_wdata <= wdata_i;
        end
        if (w_push)
            r_type[r_wr_ptr] <= we_ao;
    end
endmodule

// File: tb/tb_cpu64_obi_host_driver_mo.sv
// tb_cpu64_obi_host_driver_mo: scoreboard bench for the OBI host driver.
module tb_cpu64_obi_host_driver_mo;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rd = 1'b0, wr = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0, sel = 1'b0, resp_on = 1'b0;
    logic [7:0]  be = 8'hFF;
    logic [38:0] addr = '0;
    logic [63:0] wdata = '0, rdata = '0;

    logic        d_acc, d_req, d_we, d_rvo, d_err, d_rwe, d_busy;
    logic [7:0]  d_be;
    logic [38:0] d_addr;
    logic [63:0] d_wdata, d_rdata;
    logic        m_acc, m_req, m_we, m_rvo, m_err, m_rwe, m_busy;
    logic [7:0]  m_be;
    logic [38:0] m_addr;
    logic [63:0] m_wdata, m_rdata;
    logic        r_acc, r_req, r_we, r_rvo, r_err, r_rwe, r_busy;
    logic [7:0]  r_be;
    logic [38:0] r_addr;
    logic [63:0] r_wdata, r_rdata;

    cpu64_obi_host_driver_mo u_dut (
        .clk_i(clk), .rst_i(rst), .rd_i(rd & ~sel), .wr_i(wr & ~sel), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .stall_i(stall), .flush_i(flush & ~sel),
        .accept_ao(d_acc), .req_o(d_req), .gnt_i(gnt & ~sel), .we_ao(d_we), .be_ao(d_be),
        .addr_ao(d_addr), .wdata_ao(d_wdata), .rvalid_i(rvalid & ~sel), .rdata_i(rdata),
        .err_i(err), .rvalid_o(d_rvo), .rdata_o(d_rdata), .err_o(d_err), .rwe_o(d_rwe),
        .busy_o(d_busy)
    );

    cpu64_obi_host_driver_mo #(.MAX_OUT(3)) u_m3 (
        .clk_i(clk), .rst_i(rst), .rd_i(rd & sel), .wr_i(wr & sel), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .stall_i(stall), .flush_i(flush & sel),
        .accept_ao(m_acc), .req_o(m_req), .gnt_i(gnt & sel), .we_ao(m_we), .be_ao(m_be),
        .addr_ao(m_addr), .wdata_ao(m_wdata), .rvalid_i(rvalid & sel), .rdata_i(rdata),
        .err_i(err), .rvalid_o(m_rvo), .rdata_o(m_rdata), .err_o(m_err), .rwe_o(m_rwe),
        .busy_o(m_busy)
    );

    cpu64_obi_host_driver_mo #(.WR_EN(1'b0)) u_ro (
        .clk_i(clk), .rst_i(rst), .rd_i(1'b0), .wr_i(wr), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .stall_i(1'b0), .flush_i(1'b0),
        .accept_ao(r_acc), .req_o(r_req), .gnt_i(1'b0), .we_ao(r_we), .be_ao(r_be),
        .addr_ao(r_addr), .wdata_ao(r_wdata), .rvalid_i(1'b0), .rdata_i(rdata),
        .err_i(1'b0), .rvalid_o(r_rvo), .rdata_o(r_rdata), .err_o(r_err), .rwe_o(r_rwe),
        .busy_o(r_busy)
    );

    logic        w_acc, w_req, w_we, w_rvo, w_err, w_rwe, w_busy;
    logic [7:0]  w_be;
    logic [38:0] w_addr;
    logic [63:0] w_wdata, w_rdata;
    assign w_acc   = sel ? m_acc   : d_acc;
    assign w_req   = sel ? m_req   : d_req;
    assign w_we    = sel ? m_we    : d_we;
    assign w_be    = sel ? m_be    : d_be;
    assign w_addr  = sel ? m_addr  : d_addr;
    assign w_wdata = sel ? m_wdata : d_wdata;
    assign w_rvo   = sel ? m_rvo   : d_rvo;
    assign w_rdata = sel ? m_rdata : d_rdata;
    assign w_err   = sel ? m_err   : d_err;
    assign w_rwe   = sel ? m_rwe   : d_rwe;
    assign w_busy  = sel ? m_busy  : d_busy;

    typedef struct { int due; logic we; logic [38:0] a; } txn_t;
    typedef struct { logic we; logic [63:0] d; logic e; } exp_t;
    txn_t slave_q[$];
    exp_t exp_q[$];
    txn_t s;
    exp_t e;

    int n_chk = 0, n_err = 0, n_drop = 0, n_errfwd = 0, cyc = 0;

    function automatic logic [63:0] f_data(input logic [38:0] a);
        return {25'h0, a} ^ 64'hA5C3_0000_0000_1234;
    endfunction

    function automatic logic f_err(input logic [38:0] a);
        return a[15:12] == 4'hE;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [38:0] a);
        int n = 0;
        rd = ~we;
        wr = we;
        addr = a;
        wdata = ~{25'h0, a};
        #1;
        while (!w_acc && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("issue_acc", w_acc, 1);
        if (w_acc) exp_q.push_back('{we, f_data(a), f_err(a)});
        tick;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while ((exp_q.size() != 0 || slave_q.size() != 0) && n < 60) begin
            tick;
            n++;
        end
        chk("drain", exp_q.size(), 0);
        tick;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Interconnect model: answers granted transactions in order, LAT cycles after grant.
    always begin
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        err = 1'b0;
        if (!rst && resp_on && slave_q.size() > 0 && slave_q[0].due <= cyc) begin
            s = slave_q.pop_front();
            rvalid = 1'b1;
            rdata = f_data(s.a);
            err = f_err(s.a);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (w_rvo) begin
                if (exp_q.size() == 0)
                    chk("unexp_rvalid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rdata", w_rdata, e.d);
                    chk("rwe", w_rwe, e.we);
                    chk("err", w_err, e.e);
                end
                if (w_err) n_errfwd++;
            end
            if (rvalid && !w_rvo) n_drop++;
            if (w_req && gnt) slave_q.push_back('{cyc + LAT, w_we, w_addr});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int nd;
        logic hit;
        rd = 1'b1;
        gnt = 1'b1;
        repeat (2) tick;
        #1;
        chk("rst_acc", w_acc, 0);
        chk("rst_req", w_req, 0);
        chk("rst_busy", w_busy, 0);
        tick;
        rst = 1'b0;
        stall = 1'b1;
        addr = 39'h40;
        #1;
        chk("stall_acc", w_acc, 0);
        chk("stall_req", w_req, 0);
        chk("idle_busy", w_busy, 0);
        tick;
        stall = 1'b0;
        rd = 1'b0;
        resp_on = 1'b1;

        // write then read, plus read-only variant ignoring the write
        tick;
        wr = 1'b1;
        addr = 39'h400;
        wdata = 64'hDEAD_BEEF_0123_4567;
        be = 8'h0F;
        #1;
        chk("wr_acc", w_acc, 1);
        chk("wr_we", w_we, 1);
        chk("wr_addr", w_addr, 39'h400);
        chk("wr_wdata", w_wdata, 64'hDEAD_BEEF_0123_4567);
        chk("wr_be", w_be, 8'h0F);
        chk("ro_acc", r_acc, 0);
        chk("ro_req", r_req, 0);
        chk("ro_we", r_we, 0);
        exp_q.push_back('{1'b1, f_data(39'h400), 1'b0});
        tick;
        wr = 1'b0;
        rd = 1'b1;
        addr = 39'h408;
        be = 8'hFF;
        #1;
        chk("rd_acc", w_acc, 1);
        chk("rd_we", w_we, 0);
        exp_q.push_back('{1'b0, f_data(39'h408), 1'b0});
        tick;
        rd = 1'b0;
        drain;

        // back-to-back reads against two slots
        tick;
        rd = 1'b1;
        addr = 39'h100;
        #1;
        chk("b2b_acc0", w_acc, 1);
        exp_q.push_back('{1'b0, f_data(39'h100), 1'b0});
        tick;
        addr = 39'h108;
        #1;
        chk("b2b_acc1", w_acc, 1);
        exp_q.push_back('{1'b0, f_data(39'h108), 1'b0});
        tick;
        addr = 39'h110;
        #1;
        chk("b2b_acc2_full", w_acc, 0);
        chk("b2b_rvo", w_rvo, 1);
        tick;
        #1;
        chk("b2b_acc3", w_acc, 1);
        exp_q.push_back('{1'b0, f_data(39'h110), 1'b0});
        tick;
        rd = 1'b0;
        drain;

        // grant withheld: attributes held independent of upstream
        gnt = 1'b0;
        tick;
        rd = 1'b1;
        addr = 39'h200;
        #1;
        chk("hold_acc", w_acc, 1);
        chk("hold_req0", w_req, 1);
        exp_q.push_back('{1'b0, f_data(39'h200), 1'b0});
        for (int i = 1; i < 3; i++) begin
            tick;
            addr = 39'h300;
            #1;
            chk("hold_req", w_req, 1);
            chk("hold_addr", w_addr, 39'h200);
            chk("hold_noacc", w_acc, 0);
        end
        tick;
        gnt = 1'b1;
        #1;
        chk("hold_gnt_addr", w_addr, 39'h200);
        chk("hold_gnt_acc", w_acc, 0);
        tick;
        #1;
        chk("after_acc", w_acc, 1);
        chk("after_addr", w_addr, 39'h300);
        exp_q.push_back('{1'b0, f_data(39'h300), 1'b0});
        tick;
        rd = 1'b0;
        drain;

        // flush with two outstanding and one held (three-slot instance)
        tick;
        sel = 1'b1;
        resp_on = 1'b0;
        rd = 1'b1;
        addr = 39'h500;
        #1;
        chk("fl_acc0", w_acc, 1);
        tick;
        addr = 39'h508;
        #1;
        chk("fl_acc1", w_acc, 1);
        tick;
        gnt = 1'b0;
        addr = 39'h510;
        #1;
        chk("fl_acc2", w_acc, 1);
        tick;
        rd = 1'b0;
        flush = 1'b1;
        exp_q.delete();
        nd = n_drop;
        #1;
        chk("fl_held_req", w_req, 1);
        chk("fl_busy", w_busy, 1);
        tick;
        flush = 1'b0;
        gnt = 1'b1;
        #1;
        chk("fl_held_addr", w_addr, 39'h510);
        tick;
        rd = 1'b1;
        addr = 39'h518;
        #1;
        chk("fl_full_acc", w_acc, 0);
        resp_on = 1'b1;
        tick;
        issue(1'b0, 39'h518);
        drain;
        chk("fl_dropped", n_drop - nd, 3);
        tick;
        sel = 1'b0;

        // flush coincident with a response, two outstanding
        resp_on = 1'b0;
        issue(1'b0, 39'h600);
        issue(1'b0, 39'h608);
        #1;
        resp_on = 1'b1;
        nd = n_drop;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick;
            #1;
            if (rvalid) begin
                flush = 1'b1;
                exp_q.delete();
                hit = 1'b1;
                #1;
                chk("flrv_rvo", w_rvo, 0);
            end
        end
        chk("flrv_seen", hit, 1);
        tick;
        flush = 1'b0;
        issue(1'b0, 39'h610);
        drain;
        chk("flrv_dropped", n_drop - nd, 2);

        // error response, then reset mid-transaction
        issue(1'b0, 39'hE000);
        drain;
        chk("err_fwd", n_errfwd, 1);
        resp_on = 1'b0;
        issue(1'b0, 39'h700);
        gnt = 1'b0;
        issue(1'b0, 39'h708);
        #1;
        chk("prerst_busy", w_busy, 1);
        chk("prerst_req", w_req, 1);
        tick;
        rst = 1'b1;
        rd = 1'b1;
        addr = 39'h710;
        #1;
        chk("inrst_acc", w_acc, 0);
        chk("inrst_req", w_req, 0);
        chk("inrst_busy", w_busy, 0);
        tick;
        rst = 1'b0;
        rd = 1'b0;
        slave_q.delete();
        exp_q.delete();
        #1;
        chk("postrst_busy", w_busy, 0);
        chk("postrst_req", w_req, 0);
        tick;
        gnt = 1'b1;
        resp_on = 1'b1;
        issue(1'b0, 39'h800);
        drain;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
